// File: rtl/mult_seq_param_if.sv
// ---------------------------------------------------------------------------
// mult_seq_param_if
// Operand/result handshake bundle for the iterative shift-add multiplier.
//   in_valid / in_ready : operand transaction handshake (producer -> core)
//   in_signed           : 1 = operands are two's complement, 0 = unsigned
//   A, B                : WIDTH-bit multiplicand and multiplier
//   out_valid/out_ready : result handshake (core -> consumer), P held until taken
//   P                   : 2*WIDTH-bit product
//   busy                : core is iterating on a transaction
// The slave modport is the multiplier core; master is whoever drives it.
// ---------------------------------------------------------------------------
interface mult_seq_param_if #(
    parameter int WIDTH = 8
);
    logic                   in_valid;
    logic                   in_ready;
    logic                   in_signed;
    logic [WIDTH-1:0]       A;
    logic [WIDTH-1:0]       B;
    logic                   out_valid;
    logic                   out_ready;
    logic [2*WIDTH-1:0]     P;
    logic                   busy;

    modport master (
        output in_valid,
        output in_signed,
        output A,
        output B,
        output out_ready,
        input  in_ready,
        input  out_valid,
        input  P,
        input  busy
    );

    modport slave (
        input  in_valid,
        input  in_signed,
        input  A,
        input  B,
        input  out_ready,
        output in_ready,
        output out_valid,
        output P,
        output busy
    );
endinterface

// File: rtl/mult_seq_param.sv
// ---------------------------------------------------------------------------
// mult_seq_param
// Parametrised iterative shift-add multiplier. Operands are accepted in IDLE,
// reduced to magnitudes plus a result-sign flag, and BPC multiplier bits are
// retired per cycle for STEPS = WIDTH/BPC cycles. The product is presented
// on a held valid/ready output handshake.
// Ports:
//   clk   : rising-edge clock
//   rst_n : asynchronous active-low reset
//   bus   : mult_seq_param_if slave modport (operand and result handshakes)
// Parameters:
//   WIDTH : operand width, >= 2 and a multiple of BPC
//   BPC   : multiplier bits retired per cycle (1, 2 or 4)
// ---------------------------------------------------------------------------
module mult_seq_param #(
    parameter int WIDTH = 8,
    parameter int BPC   = 2
) (
    input  logic            clk,
    input  logic            rst_n,
    mult_seq_param_if.slave bus
);

    localparam int STEPS  = WIDTH / BPC;
    localparam int STEP_W = (STEPS > 1) ? $clog2(STEPS) : 1;
    localparam int PW     = 2 * WIDTH;

    typedef enum logic [1:0] {
        S_IDLE,
        S_BUSY,
        S_DONE
    } state_t;

    state_t              r_state;
    state_t              w_nextState;

    logic [WIDTH-1:0]    r_magA;
    logic [WIDTH-1:0]    r_magB;
    logic                r_neg;
    logic [PW-1:0]       r_acc;
    logic [PW-1:0]       r_p;
    logic [STEP_W-1:0]   r_step;
    logic                r_outValid;

    logic                w_accept;
    logic                w_lastStep;
    logic [WIDTH-1:0]    w_magAIn;
    logic [WIDTH-1:0]    w_magBIn;
    logic                w_negIn;
    logic [PW-1:0]       w_aExt;
    logic [PW-1:0]       w_digitExt;
    logic [PW-1:0]       w_prod;
    logic [31:0]         w_shamt;
    logic [PW-1:0]       w_row;
    logic [PW-1:0]       w_sum;
    logic [PW-1:0]       w_result;

    // Operand conditioning. The magnitude lives in WIDTH unsigned bits, so the
    // most-negative input negates to 2^(WIDTH-1) without losing information.
    always_comb begin
        w_accept = (r_state == S_IDLE) && bus.in_valid;
        w_magAIn = (bus.in_signed && bus.A[WIDTH-1]) ? -bus.A : bus.A;
        w_magBIn = (bus.in_signed && bus.B[WIDTH-1]) ? -bus.B : bus.B;
        w_negIn  = bus.in_signed && (bus.A[WIDTH-1] ^ bus.B[WIDTH-1]);
    end

    // One partial-product row per cycle: magnitude A times the low BPC bits of
    // the (already shifted) multiplier, aligned to the current step position.
    // The final product is formed from acc+row so the last row needs no extra
    // cycle, and the sign is applied only once at the end.
    always_comb begin
        w_aExt     = PW'(r_magA);
        w_digitExt = PW'(r_magB[BPC-1:0]);
        w_prod     = w_aExt * w_digitExt;
        w_shamt    = 32'(r_step) * 32'(BPC);
        w_row      = w_prod << w_shamt;
        w_sum      = r_acc + w_row;
        w_result   = r_neg ? -w_sum : w_sum;
        w_lastStep = (r_step == STEP_W'(STEPS - 1));
    end

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_nextState;
        end
    end

    // Next-state logic. Operands offered outside IDLE are simply not seen.
    always_comb begin
        w_nextState = r_state;
        case (r_state)
            S_IDLE: if (bus.in_valid) w_nextState = S_BUSY;
            S_BUSY: if (w_lastStep)   w_nextState = S_DONE;
            S_DONE: if (bus.out_ready) w_nextState = S_IDLE;
            default: w_nextState = S_IDLE;
        endcase
    end

    // Datapath registers. Reset clears everything, dropping any in-flight
    // transaction. P is only rewritten on completion so it stays stable
    // while DONE waits for the consumer.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_magA     <= '0;
            r_magB     <= '0;
            r_neg      <= 1'b0;
            r_acc      <= '0;
            r_step     <= '0;
            r_p        <= '0;
            r_outValid <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (w_accept) begin
                        r_magA <= w_magAIn;
                        r_magB <= w_magBIn;
                        r_neg  <= w_negIn;
                        r_acc  <= '0;
                        r_step <= '0;
                    end
                end
                S_BUSY: begin
                    r_acc  <= w_sum;
                    r_magB <= r_magB >> BPC;
                    r_step <= r_step + STEP_W'(1);
                    if (w_lastStep) begin
                        r_p        <= w_result;
                        r_outValid <= 1'b1;
                    end
                end
                S_DONE: begin
                    if (bus.out_ready) begin
                        r_outValid <= 1'b0;
                    end
                end
                default: begin
                    r_outValid <= 1'b0;
                end
            endcase
        end
    end

    // All outputs come straight from registers or state decode.
    assign bus.in_ready  = (r_state == S_IDLE);
    assign bus.busy      = (r_state == S_BUSY);
    assign bus.out_valid = r_outValid;
    assign bus.P         = r_p;

endmodule
